// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl: sequences a combinational Mandelbrot step core from z=0
// and reports the escape iteration count over valid/ready handshakes.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int FRAC     = WIDTH - 3,
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] step_cr,
  output logic signed [WIDTH-1:0] step_ci,
  output logic signed [WIDTH-1:0] step_zr,
  output logic signed [WIDTH-1:0] step_zi,
  input  logic signed [WIDTH-1:0] step_out_zr,
  input  logic signed [WIDTH-1:0] step_out_zi,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CNT_W-1:0]        res_iter,
  output logic                    res_escaped
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam logic signed [2*WIDTH:0] LIM = (2*WIDTH+1)'(4) << (2*FRAC);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, iter_q, iter_d;
  logic esc_q, esc_d;
  logic signed [2*WIDTH:0] zr_x, zi_x, mag;
  // full-precision magnitude so the escape test never sees truncation
  assign zr_x = (2*WIDTH+1)'(zr_q);
  assign zi_x = (2*WIDTH+1)'(zi_q);
  assign mag  = zr_x * zr_x + zi_x * zi_x;
  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    esc_d   = esc_q;
    unique case (state_q)
      IDLE: if (start_valid) begin
        cr_d    = cr;
        ci_d    = ci;
        zr_d    = '0;
        zi_d    = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: if (enable) begin
        if (mag > LIM || cnt_q == MAX_C) begin
          esc_d   = mag > LIM;
          iter_d  = cnt_q;
          state_d = DONE;
        end else begin
          zr_d  = step_out_zr;
          zi_d  = step_out_zi;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cr_q    <= '0;
      ci_q    <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      esc_q   <= esc_d;
    end
  end
  assign start_ready = state_q == IDLE;
  assign res_valid   = state_q == DONE;
  assign res_iter    = iter_q;
  assign res_escaped = esc_q;
  assign step_cr     = cr_q;
  assign step_ci     = ci_q;
  assign step_zr     = zr_q;
  assign step_zi     = zi_q;
endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// tb_mandelbrot_iter_ctrl: scoreboard bench with a behavioural step core and
// a reference iteration model producing the expected (iter, escaped) pairs.
module tb_mandelbrot_iter_ctrl;
  localparam int W = 8;
  localparam int F = 5;
  logic clk = 0, reset = 1, enable = 1, start_valid = 0, res_ready = 1;
  logic start_ready, res_valid, res_escaped;
  logic signed [W-1:0] cr = 0, ci = 0;
  logic signed [W-1:0] step_cr, step_ci, step_zr, step_zi, step_out_zr, step_out_zi;
  logic [7:0] res_iter;
  int n_chk = 0, n_err = 0, cyc = 0, k0 = 0;
  logic [8:0] exp_q[$];
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  mandelbrot_iter_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start_valid(start_valid), .start_ready(start_ready),
    .cr(cr), .ci(ci),
    .step_cr(step_cr), .step_ci(step_ci), .step_zr(step_zr), .step_zi(step_zi),
    .step_out_zr(step_out_zr), .step_out_zi(step_out_zi),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_iter(res_iter), .res_escaped(res_escaped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] step(input logic signed [W-1:0] a, b, zr, zi);
    int r, i;
    r = ((int'(zr) * int'(zr) - int'(zi) * int'(zi)) >>> F) + int'(a);
    i = ((2 * int'(zr) * int'(zi)) >>> F) + int'(b);
    return {r[W-1:0], i[W-1:0]};
  endfunction

  assign {step_out_zr, step_out_zi} = step(step_cr, step_ci, step_zr, step_zi);

  function automatic logic [8:0] model(input logic signed [W-1:0] a, b);
    logic signed [W-1:0] zr, zi;
    logic [2*W-1:0] s;
    zr = 0;
    zi = 0;
    for (int n = 0; n <= 255; n++) begin
      if (int'(zr) * int'(zr) + int'(zi) * int'(zi) > (4 << (2 * F))) return {8'(n), 1'b1};
      if (n == 255) return {8'(n), 1'b0};
      s  = step(a, b, zr, zi);
      zr = s[2*W-1:W];
      zi = s[W-1:0];
    end
    return '0;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("res_iter", res_iter, e[8:1]);
        chk("res_escaped", res_escaped, e[0]);
      end
    end
  end

  task automatic send(input logic signed [W-1:0] a, b);
    int n = 0;
    start_valid = 1;
    cr = a;
    ci = b;
    while (!start_ready && n < 600) begin @(negedge clk); n++; end
    chk("accept", start_ready, 1);
    k0 = cyc;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start_valid = 0;
  endtask

  task automatic wait_res(input string tag, input int lat);
    int n = 0;
    while (!res_valid && n < 600) begin @(negedge clk); n++; end
    chk(tag, cyc - k0, lat);
  endtask

  initial begin
    int n = 0;
    #1;
    chk("rst_ready", start_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_iter", res_iter, 0);
    @(negedge clk);
    reset = 0;
    send(96, 0);
    chk("step_cr", step_cr, 96);
    wait_res("lat_96", 3);
    send(32, 0);
    wait_res("lat_32", 5);
    send(0, 0);
    wait_res("lat_0", 257);
    send(0, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("mid_ready", start_ready, 1);
    chk("mid_valid", res_valid, 0);
    chk("mid_iter", res_iter, 0);
    chk("mid_zr", step_zr, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    res_ready = 0;
    send(96, 0);
    for (int i = 0; i < 4; i++) begin enable = pat[i]; @(negedge clk); end
    enable = 1;
    wait_res("lat_en", 5);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_iter", res_iter, 1);
      chk("hold_esc", res_escaped, 1);
      if (i == 2) begin start_valid = 1; cr = 32; end
      if (i == 3) begin chk("done_ready", start_ready, 0); start_valid = 0; end
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    chk("idle_ready", start_ready, 1);
    chk("idle_valid", res_valid, 0);
    send(32, 0);
    wait_res("lat_after", 5);
    send(96, 0);
    send(0, 0);
    while (exp_q.size() > 0 && n < 1000) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
- Iteration sequencer for the combinational Mandelbrot step core (inputs in_cr/in_ci/in_zr/in_zi, outputs out_zr/out_zi).
- Accepts a point c over a valid/ready handshake and starts from z=0.
- Each enabled cycle it feeds the step core's outputs back into its inputs, tests escape |z|^2 > 4, and counts iterations.
- Returns the iteration count and an escaped flag over a second valid/ready handshake.

Parameters:
- WIDTH, 8, signed two's-complement width of cr, ci, zr, zi.
- FRAC, WIDTH-3, fractional bits; with defaults the range is [-4.0, 4.0) and 1.0 = 32.
- CNT_W, 8, width of the iteration counter.
- MAX_ITER, 255, iteration cap; must be ≤ 2^CNT_W - 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  iteration advance enable; 0 freezes the ITER state.
- start_valid  in  1  new point offered.
- start_ready  out  1  block can accept a point.
- cr  in  WIDTH  real part of c, sampled on start handshake.
- ci  in  WIDTH  imaginary part of c, sampled on start handshake.
- step_cr  out  WIDTH  latched cr to the step core.
- step_ci  out  WIDTH  latched ci to the step core.
- step_zr  out  WIDTH  current zr to the step core.
- step_zi  out  WIDTH  current zi to the step core.
- step_out_zr  in  WIDTH  next zr from the step core (combinational).
- step_out_zi  in  WIDTH  next zi from the step core (combinational).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_iter  out  CNT_W  number of step applications performed.
- res_escaped  out  1  1 = escaped, 0 = hit MAX_ITER.

Behaviour:
- Reset (async, any state): state=IDLE; c, z, cnt, res_iter, res_escaped all 0; start_ready=1; res_valid=0.
- FSM states are IDLE, ITER and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch cr/ci, set z=0 and cnt=0, go to ITER.
- ITER:
  - start_ready=0. No action while enable=0; all registers hold.
  - When enable=1, evaluate in priority order:
  - (1) mag = zr*zr + zi*zi, computed signed at 2*WIDTH+1 bits with no truncation. If mag > (4 << 2*FRAC): res_escaped=1, res_iter=cnt, go to DONE.
  - (2) Else if cnt == MAX_ITER: res_escaped=0, res_iter=cnt, go to DONE.
  - (3) Else z <= {step_out_zr, step_out_zi} and cnt <= cnt+1.
  - mag == 4.0 exactly does not escape.
- DONE:
  - res_valid=1, start_ready=0; start_valid is ignored.
  - When res_ready=1, go to IDLE next cycle. No IDLE bypass: back-to-back points need one IDLE cycle.
- res_iter and res_escaped are registered. They are stable from DONE entry until the next start handshake.
- step_* outputs are direct register values. The block has no combinational path from step_out_* to any output.
- Latency, with enable held high: res_valid rises res_iter+2 cycles after the start handshake edge. Worst case is MAX_ITER+2.
- Overflow: the step core's wraparound is not compensated. The escape test applies only to registered z.
- Reset mid-ITER or mid-DONE: the result is discarded and the block returns to IDLE immediately.

Test Plan:
- Bench step model: zr' = (zr^2 - zi^2) >> FRAC + cr, zi' = (2*zr*zi) >> FRAC + ci, wrapped to WIDTH. Defaults throughout.
- Reset: assert reset asynchronously mid-cycle during ITER -> start_ready=1, res_valid=0, res_iter=0 before the next clk edge.
- cr=96 (3.0), ci=0, enable=1 -> res_valid 3 cycles after accept; res_iter=1, res_escaped=1.
- cr=32 (1.0), ci=0 -> z sequence 0, 1.0, 2.0 (mag=4.0, no escape), then wrap to -3.0 -> res_iter=3, res_escaped=1.
- cr=0, ci=0 -> res_iter=255, res_escaped=0, res_valid at accept+257.
- cr=96, ci=0 with enable toggling 1,0,0,1 and res_ready held 0 for 5 cycles after res_valid:
  - result holds, res_iter=1.
  - A start_valid pulse during DONE is not accepted.
  - After res_ready: IDLE for one cycle, then the next point is accepted.
- Back-to-back: cr=96 then cr=0 with res_ready=1 permanently -> two results (1,1) then (255,0). The second latch of c is unaffected by the first point.
